// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped, one-word-per-block instruction cache sitting between the
// pipelined datapath (fetch side) and the memory controller (fill side).
// Hits are answered combinationally; misses are filled with a single-word
// request/wait handshake. There is no write path.
//
// Optional build macro: ICACHE_STATS_EN
//   When defined, adds o_hit_count / o_miss_count performance counters.
//
// Ports
//   i_clk         system clock, all state changes on the rising edge
//   i_rst         asynchronous, active-high reset
//   i_imemren     datapath fetch request
//   i_imemaddr    fetch byte address (bits [1:0] ignored)
//   o_ihit        requested word valid this cycle
//   o_imemload    instruction word, 0 when o_ihit=0
//   i_iflush      invalidate all frames
//   o_iren        read request to memory controller
//   o_iaddr       word-aligned fill address, 0 outside a fill
//   i_iwait       memory busy; i_iload is valid when low during a fill
//   i_iload       fill data from memory
//   o_hit_count   (ICACHE_STATS_EN) cycles with o_ihit=1, wraps
//   o_miss_count  (ICACHE_STATS_EN) fills started, wraps
// -----------------------------------------------------------------------------
module icache_responder #(
    parameter int SETS    = 16,
    parameter int INDEX_W = $clog2(SETS),
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_imemren,
    input  logic [31:0] i_imemaddr,
    output logic        o_ihit,
    output logic [31:0] o_imemload,
    input  logic        i_iflush,
    output logic        o_iren,
    output logic [31:0] o_iaddr,
    input  logic        i_iwait,
    input  logic [31:0] i_iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Word address (byte address >> 2) of the fill in flight.
    logic [29:0]      r_fill_addr;

    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_ihit;
    logic               w_start_fill;
    logic               w_fill_we;
    logic               w_unused_lsbs;

    assign w_idx      = i_imemaddr[INDEX_W+1:2];
    assign w_tag      = i_imemaddr[31:INDEX_W+2];
    assign w_fill_idx = r_fill_addr[INDEX_W-1:0];
    assign w_fill_tag = r_fill_addr[29:INDEX_W];

    // Byte-offset bits never take part in lookup or fill addressing.
    assign w_unused_lsbs = ^i_imemaddr[1:0];

    // A hit is only reported from IDLE so a completing fill is never
    // answered in the same cycle it is written; flush masks hits outright.
    assign w_ihit = i_imemren & ~i_iflush & (r_state == ST_IDLE)
                  & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

    assign o_ihit     = w_ihit;
    assign o_imemload = w_ihit ? r_data[w_idx] : 32'd0;

    always_comb begin
        w_state_next = r_state;
        w_start_fill = 1'b0;
        w_fill_we    = 1'b0;
        o_iren       = 1'b0;
        o_iaddr      = 32'd0;
        case (r_state)
            ST_IDLE: begin
                // Flush wins over a simultaneous miss.
                if (i_imemren && !w_ihit && !i_iflush) begin
                    w_state_next = ST_FETCH;
                    w_start_fill = 1'b1;
                end
            end
            ST_FETCH: begin
                o_iren  = 1'b1;
                o_iaddr = {r_fill_addr, 2'b00};
                if (i_iflush) begin
                    // In-flight data is discarded even if it arrives now.
                    w_state_next = ST_IDLE;
                end else if (!i_iwait) begin
                    w_fill_we    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_fill_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_fill) begin
                r_fill_addr <= i_imemaddr[31:2];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_iflush) begin
            r_valid <= '0;
        end else if (w_fill_we) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: the valid bits alone qualify their contents.
    always_ff @(posedge i_clk) begin
        if (w_fill_we) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= i_iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hit_count  <= 32'd0;
            o_miss_count <= 32'd0;
        end else begin
            if (w_ihit) begin
                o_hit_count <= o_hit_count + 32'd1;
            end
            if (w_start_fill) begin
                o_miss_count <= o_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
